// File: rtl/alu_seq.sv
// alu_seq: accumulator-style ALU with single-cycle logic/shift ops and
// multi-cycle signed Booth multiply and restoring divide.
module alu_seq #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         Clear,
  input  logic         Yin,
  input  logic         Zin,
  input  logic [4:0]   op,
  input  logic [W-1:0] BusMuxOut,
  output logic [W-1:0] Zhi,
  output logic [W-1:0] Zlo,
  output logic         busy,
  output logic         done,
  output logic         div0
);

  localparam int unsigned SW = $clog2(W);
  localparam int unsigned CW = SW + 1;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;

  typedef enum logic [1:0] {IDLE, RUN_MUL, RUN_DIV, DONE} state_t;

  state_t        state;
  logic [W-1:0]  y;
  logic [W-1:0]  mcand;   // Booth multiplicand, or divisor magnitude
  logic [W-1:0]  lo;      // Booth multiplier/product low, or dividend/quotient
  logic [W:0]    acc;     // Booth partial product high, or partial remainder
  logic          qm1;     // Booth q(-1) bit
  logic          q_neg;   // quotient must be negated
  logic          r_neg;   // remainder takes the dividend's (negative) sign
  logic          b_zero;  // divisor was zero
  logic [CW-1:0] cnt;

  logic [SW-1:0] amt;
  logic [CW-1:0] amt_inv;
  logic [W-1:0]  sc_res;
  logic          sc_valid;
  logic [W-1:0]  a_abs;
  logic [W-1:0]  b_abs;
  logic          last;

  logic [W:0]    m_ext;
  logic [W:0]    booth_sum;
  logic [W:0]    booth_acc;
  logic [W-1:0]  booth_lo;

  logic [W:0]    div_shift;
  logic [W:0]    div_trial;
  logic          div_ok;
  logic [W:0]    div_acc;
  logic [W-1:0]  div_lo;
  logic [W-1:0]  quo;
  logic [W-1:0]  rem;

  assign amt     = BusMuxOut[SW-1:0];
  assign amt_inv = CW'(W) - {1'b0, amt};
  assign a_abs   = y[W-1] ? -y : y;
  assign b_abs   = BusMuxOut[W-1] ? -BusMuxOut : BusMuxOut;
  assign last    = (cnt == CW'(W - 1));

  // Single-cycle result; amount W-amt of W (amt=0) shifts everything out.
  always_comb begin
    sc_res   = '0;
    sc_valid = 1'b1;
    case (op)
      OP_ADD:  sc_res = y + BusMuxOut;
      OP_SUB:  sc_res = y - BusMuxOut;
      OP_AND:  sc_res = y & BusMuxOut;
      OP_OR:   sc_res = y | BusMuxOut;
      OP_ROR:  sc_res = (y >> amt) | (y << amt_inv);
      OP_ROL:  sc_res = (y << amt) | (y >> amt_inv);
      OP_SHR:  sc_res = y >> amt;
      OP_SHRA: sc_res = $signed(y) >>> amt;
      OP_SHL:  sc_res = y << amt;
      OP_NEG:  sc_res = -BusMuxOut;
      OP_NOT:  sc_res = ~BusMuxOut;
      default: sc_valid = 1'b0;
    endcase
  end

  // Radix-2 Booth step: add/subtract multiplicand, then arithmetic shift right.
  assign m_ext = {mcand[W-1], mcand};
  always_comb begin
    booth_sum = acc;
    case ({lo[0], qm1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
  end
  assign booth_acc = {booth_sum[W], booth_sum[W:1]};
  assign booth_lo  = {booth_sum[0], lo[W-1:1]};

  // Restoring division step on magnitudes; divide-by-zero leaves |A| as remainder.
  assign div_shift = {acc[W-1:0], lo[W-1]};
  assign div_trial = div_shift - {1'b0, mcand};
  assign div_ok    = ~div_trial[W];
  assign div_acc   = div_ok ? div_trial : div_shift;
  assign div_lo    = {lo[W-2:0], div_ok};
  assign quo       = b_zero ? '1 : (q_neg ? -div_lo : div_lo);
  assign rem       = r_neg ? -div_acc[W-1:0] : div_acc[W-1:0];

  // Control FSM, operand capture, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      state  <= IDLE;
      y      <= '0;
      Zhi    <= '0;
      Zlo    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      lo     <= '0;
      acc    <= '0;
      qm1    <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      b_zero <= 1'b0;
    end else begin
      if (Yin) y <= BusMuxOut;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (Zin) begin
            div0 <= 1'b0;
            cnt  <= '0;
            if (op == OP_MUL) begin
              mcand <= y;
              lo    <= BusMuxOut;
              acc   <= '0;
              qm1   <= 1'b0;
              busy  <= 1'b1;
              state <= RUN_MUL;
            end else if (op == OP_DIV) begin
              mcand  <= b_abs;
              lo     <= a_abs;
              acc    <= '0;
              q_neg  <= y[W-1] ^ BusMuxOut[W-1];
              r_neg  <= y[W-1];
              b_zero <= (BusMuxOut == '0);
              busy   <= 1'b1;
              state  <= RUN_DIV;
            end else if (sc_valid) begin
              Zlo <= sc_res;
              Zhi <= '0;
            end
          end
        end
        RUN_MUL: begin
          acc <= booth_acc;
          lo  <= booth_lo;
          qm1 <= lo[0];
          cnt <= cnt + CW'(1);
          if (last) begin
            Zhi   <= booth_acc[W-1:0];
            Zlo   <= booth_lo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        RUN_DIV: begin
          acc <= div_acc;
          lo  <= div_lo;
          cnt <= cnt + CW'(1);
          if (last) begin
            Zhi   <= rem;
            Zlo   <= quo;
            div0  <= b_zero;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
